// File: rtl/stage_sequencer_if.sv
// Bundle between the core control path and the stage sequencer.
// The master side drives opcode/mem_ready/resume; the slave side returns stage and strobes.
interface stage_sequencer_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       resume;
   logic [2:0] stage;
   logic       pc_write;
   logic       ir_write;
   logic       aux_push_pop;
   logic       stall;
   logic       halted;
   logic       mem_err;

   modport master (
      output opcode, mem_ready, resume,
      input  stage, pc_write, ir_write, aux_push_pop, stall, halted, mem_err
   );

   modport slave (
      input  opcode, mem_ready, resume,
      output stage, pc_write, ir_write, aux_push_pop, stall, halted, mem_err
   );
endinterface

// File: rtl/stage_sequencer.sv
// Five-stage multicycle sequencer with MUL/DIV and LW/SW stretch plus HALT/resume.
// Define MEM_TIMEOUT_EN to bound the memory wait and raise the sticky mem_err flag.
module stage_sequencer #(
   parameter int MUL_LAT     = 4,
   parameter int DIV_LAT     = 8,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   stage_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {RUN, WAIT_EX, WAIT_MEM, HALTED} state_t;

   localparam logic [2:0] ST_IF  = 3'd0;
   localparam logic [2:0] ST_ID  = 3'd1;
   localparam logic [2:0] ST_EX  = 3'd2;
   localparam logic [2:0] ST_MEM = 3'd3;
   localparam logic [2:0] ST_WB  = 3'd4;

   localparam logic [5:0] OP_MUL  = 6'b011100;
   localparam logic [5:0] OP_DIV  = 6'b000101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);
   localparam logic [3:0] DIV_LOAD = 4'(DIV_LAT - 1);

   if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
      $error("stage_sequencer: MUL_LAT must be 1..15");
   end
   if (DIV_LAT < 1 || DIV_LAT > 15) begin : g_bad_div_lat
      $error("stage_sequencer: DIV_LAT must be 1..15");
   end
   if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_mem_timeout
      $error("stage_sequencer: MEM_TIMEOUT must be 1..255");
   end

   state_t     state_q, state_d;
   logic [2:0] stage_q, stage_d;
   logic [3:0] cnt_q, cnt_d;
   logic       mem_op_q, mem_op_d;
   logic       pc_write_q, pc_write_d;
   logic       ir_write_q, ir_write_d;
   logic       aux_q, aux_d;
   logic       stall_q, stall_d;
   logic       halted_q, halted_d;
   logic       tmo_hit;

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);
   logic [7:0] tmo_q, tmo_d;
   logic       mem_err_q, mem_err_d;

   // tmo_q counts completed wait cycles, so the MEM_TIMEOUT-th wait cycle is the last one.
   assign tmo_hit = (tmo_q == TMO_LAST);

   always_comb begin
      tmo_d     = 8'd0;
      mem_err_d = mem_err_q;
      if (state_q == WAIT_MEM && state_d == WAIT_MEM) begin
         tmo_d = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
      end
      if (state_q == WAIT_MEM && !bus.mem_ready && tmo_hit) begin
         mem_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_q     <= 8'd0;
         mem_err_q <= 1'b0;
      end else begin
         tmo_q     <= tmo_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign bus.mem_err = mem_err_q;
`else
   assign tmo_hit     = 1'b0;
   assign bus.mem_err = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      stage_d    = stage_q;
      cnt_d      = cnt_q;
      mem_op_d   = mem_op_q;
      pc_write_d = 1'b0;
      aux_d      = 1'b0;
      unique case (state_q)
         RUN: begin
            case (stage_q)
               ST_IF: stage_d = ST_ID;
               ST_ID: begin
                  if (bus.opcode == OP_HALT) begin
                     state_d = HALTED;
                  end else begin
                     // Instruction class is captured here; opcode is a don't-care afterwards.
                     stage_d  = ST_EX;
                     aux_d    = 1'b1;
                     mem_op_d = (bus.opcode == OP_LW) || (bus.opcode == OP_SW);
                     cnt_d    = (bus.opcode == OP_MUL) ? MUL_LOAD :
                                (bus.opcode == OP_DIV) ? DIV_LOAD : 4'd0;
                  end
               end
               ST_EX: begin
                  if (cnt_q != 4'd0) begin
                     state_d = WAIT_EX;
                     cnt_d   = cnt_q - 4'd1;
                  end else begin
                     stage_d = ST_MEM;
                  end
               end
               ST_MEM: begin
                  if (mem_op_q && !bus.mem_ready) state_d = WAIT_MEM;
                  else                            stage_d = ST_WB;
               end
               ST_WB: begin
                  stage_d    = ST_IF;
                  pc_write_d = 1'b1;
               end
               default: stage_d = ST_IF;
            endcase
         end
         WAIT_EX: begin
            if (cnt_q == 4'd0) begin
               state_d = RUN;
               stage_d = ST_MEM;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         WAIT_MEM: begin
            if (bus.mem_ready || tmo_hit) begin
               state_d = RUN;
               stage_d = ST_WB;
            end
         end
         HALTED: begin
            if (bus.resume) begin
               state_d    = RUN;
               stage_d    = ST_IF;
               pc_write_d = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase
      ir_write_d = (state_d == RUN) && (stage_d == ST_IF);
      stall_d    = (state_d == WAIT_EX) || (state_d == WAIT_MEM);
      halted_d   = (state_d == HALTED);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= RUN;
         stage_q    <= ST_IF;
         cnt_q      <= 4'd0;
         mem_op_q   <= 1'b0;
         pc_write_q <= 1'b0;
         ir_write_q <= 1'b0;
         aux_q      <= 1'b0;
         stall_q    <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         stage_q    <= stage_d;
         cnt_q      <= cnt_d;
         mem_op_q   <= mem_op_d;
         pc_write_q <= pc_write_d;
         ir_write_q <= ir_write_d;
         aux_q      <= aux_d;
         stall_q    <= stall_d;
         halted_q   <= halted_d;
      end
   end

   assign bus.stage        = stage_q;
   assign bus.pc_write     = pc_write_q;
   assign bus.ir_write     = ir_write_q;
   assign bus.aux_push_pop = aux_q;
   assign bus.stall        = stall_q;
   assign bus.halted       = halted_q;
endmodule
